// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller that sits directly upstream of
// ControlUnit. It turns load-use hazards, control redirects (taken branch,
// JALR, JAL) and multi-cycle data-memory waits into stall, flush and bubble
// strobes for the pipeline registers. ID_EXBubble feeds ControlUnit, which
// zeroes its control outputs into ID/EX.
//
// Handshake: dmem_ready is a completion strobe for the access that
// MEM_MemReq marks as active in MEM. While MEM_MemReq=1 and dmem_ready=0, the
// whole pipeline up to and including EX/MEM holds, and MEM/WB takes a NOP.
// The access is done in the first cycle that both are 1. No other
// valid/ready pairs exist in this block.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   ID_rs1/ID_rs2       source registers of the instruction in ID
//   ID_UsesRs1/2        the ID instruction actually reads rs1/rs2
//   ID_JAL              JAL decoded in ID; redirect from ID
//   EX_MemReadEn/EX_rd  load in EX and its destination register
//   EX_BranchTaken      branch resolved taken in EX
//   EX_JALR             JALR in EX; redirect from EX
//   MEM_MemReq          load/store access active in MEM
//   dmem_ready          data memory completes access this cycle
//   PCWrite .. MEM_WBBubble  pipeline register strobes (combinational)
//   mem_timeout_err     sticky flag: a memory wait ran out of cycles
//   stall_cycles        saturating count of cycles with PCWrite=0
//   flush_count         saturating count of cycles with IF_IDFlush=1
//   dbgState            current FSM state (RUN/MEM_WAIT/REDIRECT)
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_UsesRs1,
  input  logic             ID_UsesRs2,
  input  logic             ID_JAL,
  input  logic             EX_MemReadEn,
  input  logic [4:0]       EX_rd,
  input  logic             EX_BranchTaken,
  input  logic             EX_JALR,
  input  logic             MEM_MemReq,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_IDWrite,
  output logic             IF_IDFlush,
  output logic             ID_EXBubble,
  output logic             ID_EXWrite,
  output logic             EX_MEMWrite,
  output logic             MEM_WBBubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbgState
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  // Wait counter value at which the current wait cycle is the last allowed.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] state;
  logic [1:0] nextState;
  logic [7:0] waitCnt;
  logic [7:0] nextWaitCnt;
  logic       setErr;

  logic memWait;
  logic exRedirect;
  logic loadUse;

  assign memWait    = MEM_MemReq & ~dmem_ready;
  assign exRedirect = EX_BranchTaken | EX_JALR;
  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign loadUse    = EX_MemReadEn & (EX_rd != 5'd0) &
                      ((ID_UsesRs1 & (ID_rs1 == EX_rd)) |
                       (ID_UsesRs2 & (ID_rs2 == EX_rd)));

  assign dbgState = state;

  // waitCnt holds the number of wait cycles already spent before the
  // current one; RUN always sees 0 because every exit path clears it. The
  // wait cycle in which waitCnt reaches WAIT_LAST is the last one allowed.
  always_comb begin
    PCWrite      = 1'b1;
    IF_IDWrite   = 1'b1;
    IF_IDFlush   = 1'b0;
    ID_EXBubble  = 1'b0;
    ID_EXWrite   = 1'b1;
    EX_MEMWrite  = 1'b1;
    MEM_WBBubble = 1'b0;
    nextState    = state;
    nextWaitCnt  = waitCnt;
    setErr       = 1'b0;

    if (rst) begin
      case (state)
        RUN: begin
          if (memWait) begin
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            ID_EXWrite   = 1'b0;
            EX_MEMWrite  = 1'b0;
            MEM_WBBubble = 1'b1;
            if (WAIT_LAST == 8'd0) begin
              setErr = 1'b1;
            end else begin
              nextState   = MEM_WAIT;
              nextWaitCnt = 8'd1;
            end
          end else if (exRedirect) begin
            // The ID instruction is killed, so a coincident load-use is moot.
            IF_IDFlush  = 1'b1;
            ID_EXBubble = 1'b1;
            nextState   = REDIRECT;
          end else if (loadUse) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
          end else if (ID_JAL) begin
            IF_IDFlush = 1'b1;
          end
        end

        MEM_WAIT: begin
          if (memWait) begin
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            ID_EXWrite   = 1'b0;
            EX_MEMWrite  = 1'b0;
            MEM_WBBubble = 1'b1;
            if (waitCnt >= WAIT_LAST) begin
              setErr      = 1'b1;
              nextState   = RUN;
              nextWaitCnt = 8'd0;
            end else begin
              nextWaitCnt = waitCnt + 8'd1;
            end
          end else begin
            // Access completed: release the pipeline with default strobes.
            nextState   = RUN;
            nextWaitCnt = 8'd0;
          end
        end

        REDIRECT: begin
          // EX holds the bubble inserted by the redirect; nothing to detect.
          nextState = RUN;
        end

        default: begin
          nextState   = RUN;
          nextWaitCnt = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= RUN;
      waitCnt         <= 8'd0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= '0;
      flush_count     <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (setErr) begin
        mem_timeout_err <= 1'b1;
      end
      if (!PCWrite && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_ONE;
      end
      if (IF_IDFlush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: a table of single-cycle vectors walked in order
// (each row's expectation accounts for the state the previous row leaves),
// followed by hand-written memory-wait, timeout and reset-in-wait sequences.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  // Strobe vector: {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble,
  //                 ID_EXWrite, EX_MEMWrite, MEM_WBBubble}
  localparam logic [6:0] S_DEF   = 7'b1100110;
  localparam logic [6:0] S_LU    = 7'b0001110;
  localparam logic [6:0] S_REDIR = 7'b1111110;
  localparam logic [6:0] S_JAL   = 7'b1110110;
  localparam logic [6:0] S_MEMW  = 7'b0000001;

  logic             clk;
  logic             rst;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_UsesRs1;
  logic             ID_UsesRs2;
  logic             ID_JAL;
  logic             EX_MemReadEn;
  logic [4:0]       EX_rd;
  logic             EX_BranchTaken;
  logic             EX_JALR;
  logic             MEM_MemReq;
  logic             dmem_ready;
  logic             PCWrite;
  logic             IF_IDWrite;
  logic             IF_IDFlush;
  logic             ID_EXBubble;
  logic             ID_EXWrite;
  logic             EX_MEMWrite;
  logic             MEM_WBBubble;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       dbgState;
  logic [6:0]       strobes;

  assign strobes = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble,
                    ID_EXWrite, EX_MEMWrite, MEM_WBBubble};

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_JAL(ID_JAL), .EX_MemReadEn(EX_MemReadEn), .EX_rd(EX_rd),
    .EX_BranchTaken(EX_BranchTaken), .EX_JALR(EX_JALR),
    .MEM_MemReq(MEM_MemReq), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
    .ID_EXBubble(ID_EXBubble), .ID_EXWrite(ID_EXWrite),
    .EX_MEMWrite(EX_MEMWrite), .MEM_WBBubble(MEM_WBBubble),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .dbgState(dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
    logic       jal;
    logic       exMemRead;
    logic [4:0] exRd;
    logic       brTaken;
    logic       jalr;
    logic       memReq;
    logic       ready;
    logic [6:0] expStrobe;
    logic [1:0] expState;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int expStall = 0;
  int expFlush = 0;
  logic expErr = 1'b0;
  logic [8:0] exp_q[$];
  vec_t vecs[17];

  function automatic vec_t mkVec(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic uses1, input logic uses2,
                                 input logic jal, input logic exMemRead,
                                 input logic [4:0] exRd, input logic brTaken,
                                 input logic jalr, input logic memReq,
                                 input logic ready, input logic [6:0] expStrobe,
                                 input logic [1:0] expState);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.uses1 = uses1; v.uses2 = uses2; v.jal = jal;
    v.exMemRead = exMemRead; v.exRd = exRd; v.brTaken = brTaken;
    v.jalr = jalr; v.memReq = memReq; v.ready = ready;
    v.expStrobe = expStrobe; v.expState = expState;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic setIn(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2;
    ID_UsesRs1 = v.uses1; ID_UsesRs2 = v.uses2; ID_JAL = v.jal;
    EX_MemReadEn = v.exMemRead; EX_rd = v.exRd;
    EX_BranchTaken = v.brTaken; EX_JALR = v.jalr;
    MEM_MemReq = v.memReq; dmem_ready = v.ready;
  endtask

  task automatic setIdle();
    setIn(mkVec(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0,
                1'b0, 1'b1, S_DEF, RUN));
  endtask

  task automatic setMem(input logic memReq, input logic ready);
    setIdle();
    MEM_MemReq = memReq;
    dmem_ready = ready;
  endtask

  // Inputs are already applied; check strobes mid-cycle, then the
  // registered state, counters and error flag just after the edge.
  task automatic runCycle(input string tag, input logic [6:0] expS,
                          input logic [1:0] expSt);
    @(negedge clk);
    check({tag, " strobes"}, 32'(strobes), 32'(expS));
    if (!expS[6]) expStall++;
    if (expS[4])  expFlush++;
    @(posedge clk);
    #1;
    check({tag, " state"}, 32'(dbgState), 32'(expSt));
    check({tag, " stall_cycles"}, 32'(stall_cycles), 32'(expStall));
    check({tag, " flush_count"}, 32'(flush_count), 32'(expFlush));
    check({tag, " mem_timeout_err"}, 32'(mem_timeout_err), 32'(expErr));
  endtask

  initial begin
    // Table: each row is one cycle, applied in order from RUN after reset.
    vecs[0]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DEF,   RUN);      // idle
    vecs[1]  = mkVec(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 1, S_LU,    RUN);      // load-use rs2
    vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DEF,   RUN);      // hazard gone
    vecs[3]  = mkVec(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, S_DEF,   RUN);      // rd=x0
    vecs[4]  = mkVec(7, 0, 1, 0, 0, 1, 7, 0, 0, 0, 1, S_LU,    RUN);      // load-use rs1
    vecs[5]  = mkVec(7, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, S_DEF,   RUN);      // rs1 unused
    vecs[6]  = mkVec(0, 9, 0, 1, 0, 0, 9, 0, 0, 0, 1, S_DEF,   RUN);      // not a load
    vecs[7]  = mkVec(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, 1, S_REDIR, REDIRECT); // branch beats LU
    vecs[8]  = mkVec(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 1, S_DEF,   RUN);      // REDIRECT defaults
    vecs[9]  = mkVec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, S_JAL,   RUN);      // JAL
    vecs[10] = mkVec(3, 0, 1, 0, 1, 1, 3, 0, 0, 0, 1, S_LU,    RUN);      // LU beats JAL
    vecs[11] = mkVec(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, S_REDIR, REDIRECT); // JALR beats JAL
    vecs[12] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DEF,   RUN);      // REDIRECT idle
    vecs[13] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, S_DEF,   RUN);      // 1-cycle access
    vecs[14] = mkVec(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, S_MEMW,  MEM_WAIT); // wait beats all
    vecs[15] = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, S_DEF,   RUN);      // wait done
    vecs[16] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, S_DEF,   RUN);      // idle

    // Reset with idle inputs; strobes must be defaults while rst=0.
    rst = 1'b0;
    setIdle();
    @(negedge clk);
    check("reset strobes", 32'(strobes), 32'(S_DEF));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset state", 32'(dbgState), 32'(RUN));
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
    check("reset flush_count", 32'(flush_count), 32'd0);
    check("reset mem_timeout_err", 32'(mem_timeout_err), 32'd0);

    for (int i = 0; i < 17; i++) begin
      setIn(vecs[i]);
      runCycle($sformatf("vec%0d", i), vecs[i].expStrobe, vecs[i].expState);
    end

    // Three wait cycles, then completion, then idle.
    exp_q.push_back({S_MEMW, MEM_WAIT});
    exp_q.push_back({S_MEMW, MEM_WAIT});
    exp_q.push_back({S_MEMW, MEM_WAIT});
    exp_q.push_back({S_DEF, RUN});
    exp_q.push_back({S_DEF, RUN});
    for (int c = 0; c < 5; c++) begin
      logic [8:0] e;
      if (c < 3) setMem(1'b1, 1'b0);
      else if (c == 3) setMem(1'b1, 1'b1);
      else setIdle();
      e = exp_q.pop_front();
      runCycle($sformatf("memwait%0d", c), e[8:2], e[1:0]);
    end

    // Timeout: dmem_ready held low; the 4th wait cycle flags the error.
    setMem(1'b1, 1'b0);
    runCycle("tmo1", S_MEMW, MEM_WAIT);
    runCycle("tmo2", S_MEMW, MEM_WAIT);
    runCycle("tmo3", S_MEMW, MEM_WAIT);
    expErr = 1'b1;
    runCycle("tmo4", S_MEMW, RUN);
    runCycle("tmo5", S_MEMW, MEM_WAIT);
    setIdle();
    runCycle("tmo6", S_DEF, RUN);
    runCycle("tmo7", S_DEF, RUN);

    // Reset in the middle of a wait: aborts with no error, counters cleared.
    setMem(1'b1, 1'b0);
    runCycle("rstw1", S_MEMW, MEM_WAIT);
    rst = 1'b0;
    expStall = 0;
    expFlush = 0;
    expErr = 1'b0;
    runCycle("rstw2", S_DEF, RUN);
    rst = 1'b1;
    setIdle();
    runCycle("rstw3", S_DEF, RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller directly upstream of ControlUnit; produces the ID_EXBubble input ControlUnit uses to zero its control outputs.
- Detects load-use hazards, control redirects (taken branch, JALR, JAL) and multi-cycle data-memory waits.
- Drives stall, flush and bubble strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before abort; range 1..255.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- ID_rs1  in  5  rs1 of instruction in ID.
- ID_rs2  in  5  rs2 of instruction in ID.
- ID_UsesRs1  in  1  ID instruction reads rs1.
- ID_UsesRs2  in  1  ID instruction reads rs2.
- ID_JAL  in  1  JAL decoded in ID; redirect from ID.
- EX_MemReadEn  in  1  load in EX.
- EX_rd  in  5  destination register in EX.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- EX_JALR  in  1  JALR in EX; redirect from EX.
- MEM_MemReq  in  1  load/store access active in MEM.
- dmem_ready  in  1  data memory completes access this cycle.
- PCWrite  out  1  PC may update.
- IF_IDWrite  out  1  IF/ID may load.
- IF_IDFlush  out  1  IF/ID loads a NOP.
- ID_EXBubble  out  1  feeds ControlUnit; zeroes its controls into ID/EX.
- ID_EXWrite  out  1  ID/EX may load.
- EX_MEMWrite  out  1  EX/MEM may load.
- MEM_WBBubble  out  1  MEM/WB loads a NOP.
- mem_timeout_err  out  1  sticky; set on MEM_TIMEOUT expiry.
- stall_cycles  out  CNT_W  cycles with PCWrite=0, saturating.
- flush_count  out  CNT_W  cycles with IF_IDFlush=1, saturating.

Behaviour:
- State register: RUN (2'd0), MEM_WAIT (2'd1), REDIRECT (2'd2). Wait counter is 8 bits.
- Strobes are combinational from state and inputs (same-cycle). State, wait counter, error flag and perf counters are registered.
- Reset (rst=0 at edge):
  - state=RUN, wait counter=0, mem_timeout_err=0, counters=0.
  - While rst=0: PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, EX_MEMWrite=1; all bubble/flush outputs=0.
  - Reset mid-MEM_WAIT aborts the wait with no error set.
- Default in RUN: all Write outputs=1, all Bubble/Flush outputs=0.
- Priority, highest first: mem wait > EX redirect > load-use > ID_JAL.
- Mem wait (MEM_MemReq=1 & dmem_ready=0, in RUN or MEM_WAIT):
  - PCWrite=IF_IDWrite=ID_EXWrite=EX_MEMWrite=0, MEM_WBBubble=1.
  - All other hazard strobes are suppressed.
  - RUN->MEM_WAIT; wait counter increments each MEM_WAIT cycle.
  - dmem_ready=1 in MEM_WAIT: strobes return to defaults that cycle; next state=RUN; counter cleared.
  - Counter reaching MEM_TIMEOUT-1 while still waiting: mem_timeout_err<=1 (sticky until reset), next state=RUN, counter cleared.
- EX redirect (EX_BranchTaken | EX_JALR):
  - IF_IDFlush=1, ID_EXBubble=1; PCWrite=1 so the target loads.
  - Next state=REDIRECT for 1 cycle. REDIRECT applies default strobes, then returns to RUN.
  - A load-use condition in the same cycle is ignored, because the ID instruction is being killed.
- Load-use: EX_MemReadEn & EX_rd!=0 & ((ID_UsesRs1 & ID_rs1==EX_rd) | (ID_UsesRs2 & ID_rs2==EX_rd)).
  - PCWrite=0, IF_IDWrite=0, ID_EXBubble=1 for exactly that cycle.
  - No state change; the hazard clears once the bubble advances.
- ID_JAL with no higher-priority event: IF_IDFlush=1 only; PCWrite=1.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset, then idle inputs -> PCWrite=IF_IDWrite=ID_EXWrite=EX_MEMWrite=1; all bubbles/flushes=0; counters=0; state RUN.
- EX_MemReadEn=1, EX_rd=5, ID_rs2=5, ID_UsesRs2=1 for one cycle -> same cycle ID_EXBubble=1, PCWrite=0, IF_IDWrite=0; next cycle with EX_MemReadEn=0 -> defaults; stall_cycles=1. Repeat with EX_rd=0 -> no stall.
- EX_BranchTaken=1 together with the load-use condition -> IF_IDFlush=1, ID_EXBubble=1, PCWrite=1; flush_count=1; next cycle REDIRECT with defaults.
- MEM_MemReq=1, dmem_ready=0 for 3 cycles then dmem_ready=1 -> 3 cycles of PCWrite=0, EX_MEMWrite=0, MEM_WBBubble=1; the 4th cycle has defaults; stall_cycles=3; mem_timeout_err=0.
- MEM_TIMEOUT=4, dmem_ready held at 0 -> mem_timeout_err=1 after 4 wait cycles, state RUN; error flag holds until rst=0.
- Enter MEM_WAIT, assert rst=0 for one edge -> state RUN, all counters 0, mem_timeout_err=0, default strobes.
